// File: rtl/vend_pkg.sv
// Shared vending types: money width, coin denominations and dispenser FSM states.
package vend_pkg;
  localparam int MONEY_W = 12;
  typedef logic [MONEY_W-1:0] money_t;

  localparam money_t DOLLAR_VAL  = 12'd100;
  localparam money_t QUARTER_VAL = 12'd25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_EJECT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_JAM   = 3'd5
  } disp_state_e;
endpackage

// File: rtl/change_dispenser_coin_tube.sv
// Coin tube fill level: saturating up/down counter with full-load and empty flag.
module coin_tube #(
  parameter int MAX = 15,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         empty
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // A same-cycle deposit and dispense cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = MAX_V;
    end else if (inc && !dec) begin
      if (cnt_q != MAX_V) cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= MAX_V;
    else       cnt_q <= cnt_d;
  end

  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/change_dispenser.sv
// Refund payout engine: latches credit on a refund edge and pays it out in dollars
// then quarters, one acknowledged coin at a time, reporting any unpaid remainder.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int TUBE_MAX    = 15,
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refund,
  input  logic [11:0] balance,
  input  logic        coin_ack,
  input  logic        deposit_dollar,
  input  logic        deposit_quarter,
  input  logic [1:0]  refill,
  output logic        eject_dollar,
  output logic        eject_quarter,
  output logic        busy,
  output logic        done,
  output logic        balance_clr,
  output logic [11:0] owed,
  output logic [3:0]  dollar_cnt,
  output logic [3:0]  quarter_cnt,
  output logic        exact_change,
  output logic        jam
);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(ACK_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  disp_state_e      state_q, state_d;
  logic             refund_prev_q;
  money_t           remaining_q, remaining_d;
  money_t           owed_q, owed_d;
  logic             sel_dollar_q, sel_dollar_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             eject_dollar_q, eject_dollar_d;
  logic             eject_quarter_q, eject_quarter_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             jam_q, jam_d;

  logic             refund_edge;
  logic             dec_dollar, dec_quarter;
  logic             dollar_empty, quarter_empty;

  assign refund_edge = refund && !refund_prev_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    sel_dollar_d = sel_dollar_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    owed_d       = owed_q;
    dec_dollar   = 1'b0;
    dec_quarter  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (refund_edge) begin
          remaining_d = balance;
          state_d     = (balance != '0) ? ST_PICK : ST_DONE;
        end
      end
      ST_PICK: begin
        timer_d = '0;
        if (remaining_q >= DOLLAR_VAL && !dollar_empty) begin
          sel_dollar_d = 1'b1;
          state_d      = ST_EJECT;
        end else if (remaining_q >= QUARTER_VAL && !quarter_empty) begin
          sel_dollar_d = 1'b0;
          state_d      = ST_EJECT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        // An ack arriving on the very cycle the timer expires still counts.
        if (coin_ack) begin
          remaining_d = remaining_q - (sel_dollar_q ? DOLLAR_VAL : QUARTER_VAL);
          dec_dollar  = sel_dollar_q;
          dec_quarter = !sel_dollar_q;
          timer_d     = '0;
          gap_d       = '0;
          state_d     = ST_GAP;
        end else if (timer_q == TMR_LIMIT) begin
          state_d = ST_JAM;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_PICK;
        else                   gap_d   = gap_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_JAM:  state_d = ST_JAM;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE || state_d == ST_JAM) owed_d = remaining_d;

    eject_dollar_d  = (state_d == ST_EJECT) && sel_dollar_d;
    eject_quarter_d = (state_d == ST_EJECT) && !sel_dollar_d;
    busy_d          = (state_d == ST_PICK) || (state_d == ST_EJECT) || (state_d == ST_GAP);
    done_d          = (state_d == ST_DONE);
    jam_d           = (state_d == ST_JAM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      refund_prev_q   <= 1'b0;
      timer_q         <= '0;
      gap_q           <= '0;
      owed_q          <= '0;
      eject_dollar_q  <= 1'b0;
      eject_quarter_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      jam_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      refund_prev_q   <= refund;
      timer_q         <= timer_d;
      gap_q           <= gap_d;
      owed_q          <= owed_d;
      eject_dollar_q  <= eject_dollar_d;
      eject_quarter_q <= eject_quarter_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      jam_q           <= jam_d;
    end
  end

  // Payout datapath is always loaded before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    remaining_q  <= remaining_d;
    sel_dollar_q <= sel_dollar_d;
  end

  coin_tube #(.MAX(TUBE_MAX), .W(4)) u_dollar_tube (
    .clk   (clk),
    .reset (reset),
    .load  (refill[1] && state_q == ST_IDLE),
    .inc   (deposit_dollar),
    .dec   (dec_dollar),
    .cnt   (dollar_cnt),
    .empty (dollar_empty)
  );

  coin_tube #(.MAX(TUBE_MAX), .W(4)) u_quarter_tube (
    .clk   (clk),
    .reset (reset),
    .load  (refill[0] && state_q == ST_IDLE),
    .inc   (deposit_quarter),
    .dec   (dec_quarter),
    .cnt   (quarter_cnt),
    .empty (quarter_empty)
  );

  assign eject_dollar  = eject_dollar_q;
  assign eject_quarter = eject_quarter_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign balance_clr   = done_q;
  assign owed          = owed_q;
  assign jam           = jam_q;
  assign exact_change  = (quarter_cnt < 4'd3);
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;
  localparam int GAP = 4;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset, refund, coin_ack, deposit_dollar, deposit_quarter;
  logic [1:0]  refill;
  logic [11:0] balance;
  logic        eject_dollar, eject_quarter, busy, done, balance_clr, exact_change, jam;
  logic [11:0] owed;
  logic [3:0]  dollar_cnt, quarter_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  change_dispenser #(.TUBE_MAX(15), .ACK_TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .clk             (clk),
    .reset           (reset),
    .refund          (refund),
    .balance         (balance),
    .coin_ack        (coin_ack),
    .deposit_dollar  (deposit_dollar),
    .deposit_quarter (deposit_quarter),
    .refill          (refill),
    .eject_dollar    (eject_dollar),
    .eject_quarter   (eject_quarter),
    .busy            (busy),
    .done            (done),
    .balance_clr     (balance_clr),
    .owed            (owed),
    .dollar_cnt      (dollar_cnt),
    .quarter_cnt     (quarter_cnt),
    .exact_change    (exact_change),
    .jam             (jam)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_refund(input int bal);
    balance = 12'(bal);
    refund  = 1'b1;
    tick();
    refund  = 1'b0;
  endtask

  // Wait for the next eject, ack it 3 cycles after it rises, then check the tube.
  task automatic pay_coin(input bit is_dollar, input int exp_cnt, input int exp_wait, input bit dep_same);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(eject_dollar || eject_quarter) && n < 40);
    check("eject_wait", 32'(n), 32'(exp_wait));
    check("eject_dollar_sel", 32'(eject_dollar), 32'(is_dollar));
    check("eject_quarter_sel", 32'(eject_quarter), 32'(!is_dollar));
    tick();
    tick();
    coin_ack        = 1'b1;
    deposit_quarter = dep_same;
    tick();
    coin_ack        = 1'b0;
    deposit_quarter = 1'b0;
    check("eject_drop", 32'({eject_dollar, eject_quarter}), 32'd0);
    if (is_dollar) begin
      check("dollar_cnt_dec", 32'(dollar_cnt), 32'(exp_cnt));
    end else begin
      check("quarter_cnt_dec", 32'(quarter_cnt), 32'(exp_cnt));
      check("exact_change", 32'(exact_change), 32'(exp_cnt < 3));
    end
  endtask

  task automatic wait_done(input int exp_wait, input int exp_owed);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    check("done_wait", 32'(n), 32'(exp_wait));
    check("balance_clr_pulse", 32'(balance_clr), 32'd1);
    check("owed", 32'(owed), 32'(exp_owed));
    check("busy_at_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'({done, balance_clr}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    reset = 1'b1; refund = 1'b0; coin_ack = 1'b0;
    deposit_dollar = 1'b0; deposit_quarter = 1'b0; refill = 2'b00; balance = '0;
    tick();
    tick();
    check("rst_eject", 32'({eject_dollar, eject_quarter}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'({done, balance_clr}), 32'd0);
    check("rst_owed", 32'(owed), 32'd0);
    check("rst_jam", 32'(jam), 32'd0);
    check("rst_dollar_cnt", 32'(dollar_cnt), 32'd15);
    check("rst_quarter_cnt", 32'(quarter_cnt), 32'd15);
    check("rst_exact", 32'(exact_change), 32'd0);
    reset = 1'b0;
    tick();

    // Full payout of 225: dollar, dollar, quarter.
    start_refund(225);
    check("busy_after_edge", 32'(busy), 32'd1);
    pay_coin(1'b1, 14, 1, 1'b0);
    pay_coin(1'b1, 13, GAP + 1, 1'b0);
    pay_coin(1'b0, 14, GAP + 1, 1'b0);
    wait_done(GAP + 1, 0);
    check("full_dollar_cnt", 32'(dollar_cnt), 32'd13);
    check("full_quarter_cnt", 32'(quarter_cnt), 32'd14);

    refill = 2'b10;
    tick();
    refill = 2'b00;
    check("refill_idle", 32'(dollar_cnt), 32'd15);

    // Residue: 60 pays two quarters and leaves 10.
    do_reset();
    start_refund(60);
    pay_coin(1'b0, 14, 1, 1'b0);
    pay_coin(1'b0, 13, GAP + 1, 1'b0);
    wait_done(GAP + 1, 10);

    // Zero balance: immediate done with owed cleared.
    start_refund(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_clr", 32'(balance_clr), 32'd1);
    check("zero_owed", 32'(owed), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    tick();
    check("zero_done_end", 32'(done), 32'd0);

    // Counter boundaries.
    do_reset();
    deposit_quarter = 1'b1;
    deposit_dollar  = 1'b1;
    tick();
    deposit_quarter = 1'b0;
    deposit_dollar  = 1'b0;
    check("sat_quarter", 32'(quarter_cnt), 32'd15);
    check("sat_dollar", 32'(dollar_cnt), 32'd15);
    start_refund(50);
    refill = 2'b11;
    pay_coin(1'b0, 14, 1, 1'b0);
    pay_coin(1'b0, 14, GAP + 1, 1'b1);
    refill = 2'b00;
    wait_done(GAP + 1, 0);
    deposit_quarter = 1'b1;
    tick();
    deposit_quarter = 1'b0;
    check("deposit_inc", 32'(quarter_cnt), 32'd15);

    // Drain the dollar tube, then pay 150 entirely in quarters.
    do_reset();
    start_refund(1675);
    for (int i = 0; i < 15; i++) pay_coin(1'b1, 14 - i, (i == 0) ? 1 : GAP + 1, 1'b0);
    for (int i = 0; i < 7; i++) pay_coin(1'b0, 14 - i, GAP + 1, 1'b0);
    wait_done(GAP + 1, 0);
    check("drained_dollar", 32'(dollar_cnt), 32'd0);
    start_refund(150);
    for (int i = 0; i < 6; i++) pay_coin(1'b0, 7 - i, (i == 0) ? 1 : GAP + 1, 1'b0);
    wait_done(GAP + 1, 0);

    // Jam: no ack ever arrives.
    do_reset();
    start_refund(100);
    tick();
    check("jam_eject_rise", 32'(eject_dollar), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!jam && n < 100);
    check("jam_latency", 32'(n), 32'(TMO + 1));
    check("jam_eject_low", 32'({eject_dollar, eject_quarter}), 32'd0);
    check("jam_busy", 32'(busy), 32'd0);
    check("jam_owed", 32'(owed), 32'd100);
    start_refund(100);
    tick();
    tick();
    check("jam_sticky", 32'(jam), 32'd1);
    check("jam_no_restart", 32'({eject_dollar, eject_quarter, busy}), 32'd0);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check("jam_ack_ignored", 32'(dollar_cnt), 32'd15);
    do_reset();
    check("jam_cleared", 32'(jam), 32'd0);

    // Reset during the second gap of a 300 payout.
    start_refund(300);
    pay_coin(1'b1, 14, 1, 1'b0);
    pay_coin(1'b1, 13, GAP + 1, 1'b0);
    reset = 1'b1;
    tick();
    check("abort_eject", 32'({eject_dollar, eject_quarter}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'({done, balance_clr}), 32'd0);
    check("abort_owed", 32'(owed), 32'd0);
    check("abort_dollar_cnt", 32'(dollar_cnt), 32'd15);
    check("abort_quarter_cnt", 32'(quarter_cnt), 32'd15);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || eject_dollar) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
